// File: rtl/delay_timer_if.sv
// Serial command / status bundle between the timer controller and its user.
interface delay_timer_if #(
  parameter int DELAY_W = 4
) ();
  logic               data;
  logic               ack;
  logic               shift_ena;
  logic               counting;
  logic               done;
  logic [DELAY_W-1:0] count;

  modport master (
    output data, ack,
    input  shift_ena, counting, done, count
  );

  modport slave (
    input  data, ack,
    output shift_ena, counting, done, count
  );
endinterface

// File: rtl/delay_timer_ctrl.sv
// One-shot timer: finds PATTERN on the serial stream, shifts in a delay,
// counts (delay+1)*UNIT_CYCLES clocks, then holds done until ack.
module delay_timer_ctrl #(
  parameter int         DELAY_W     = 4,
  parameter int         UNIT_CYCLES = 1000,
  parameter logic [3:0] PATTERN     = 4'b1101
) (
  input  logic          clk,
  input  logic          reset_n,
  delay_timer_if.slave  bus
);

  localparam int SUB_W = $clog2(UNIT_CYCLES);
  localparam int SH_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;

  localparam logic [SUB_W-1:0]   SUB_LOAD = SUB_W'(UNIT_CYCLES - 1);
  localparam logic [SUB_W-1:0]   SUB_ONE  = {{(SUB_W-1){1'b0}}, 1'b1};
  localparam logic [SUB_W-1:0]   SUB_ZERO = '0;
  localparam logic [DELAY_W-1:0] CNT_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};
  localparam logic [DELAY_W-1:0] CNT_ZERO = '0;
  localparam logic [SH_W-1:0]    SH_LAST  = SH_W'(DELAY_W - 1);
  localparam logic [SH_W-1:0]    SH_ONE   = {{(SH_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         hist_reg;
  logic [SH_W-1:0]    shift_cnt_reg;
  logic [SUB_W-1:0]   sub_reg;
  logic [DELAY_W-1:0] count_reg;

  logic match;
  logic shift_last;
  logic unit_end;
  logic shift_ena_dec, counting_dec, done_dec;

  // The match includes the bit sampled on the current edge.
  assign match      = ({hist_reg, bus.data} == PATTERN);
  assign shift_last = (shift_cnt_reg == SH_LAST);
  assign unit_end   = (sub_reg == SUB_ZERO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= SEARCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_ena_dec = 1'b0;
    counting_dec  = 1'b0;
    done_dec      = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (match) state_next = SHIFT;
      end
      SHIFT: begin
        shift_ena_dec = 1'b1;
        if (shift_last) state_next = COUNT;
      end
      COUNT: begin
        counting_dec = 1'b1;
        if (unit_end && (count_reg == CNT_ZERO)) state_next = DONE;
      end
      DONE: begin
        done_dec = 1'b1;
        if (bus.ack) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  // History is held at zero outside SEARCH so every re-entry starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_reg      <= 3'b000;
      shift_cnt_reg <= '0;
      sub_reg       <= '0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        SEARCH: begin
          hist_reg      <= {hist_reg[1:0], bus.data};
          shift_cnt_reg <= '0;
        end
        SHIFT: begin
          hist_reg      <= 3'b000;
          count_reg     <= {count_reg[DELAY_W-2:0], bus.data};
          shift_cnt_reg <= shift_cnt_reg + SH_ONE;
          if (shift_last) sub_reg <= SUB_LOAD;
        end
        COUNT: begin
          hist_reg <= 3'b000;
          if (!unit_end) begin
            sub_reg <= sub_reg - SUB_ONE;
          end else if (count_reg != CNT_ZERO) begin
            count_reg <= count_reg - CNT_ONE;
            sub_reg   <= SUB_LOAD;
          end
        end
        DONE: begin
          hist_reg <= 3'b000;
        end
        default: begin
          hist_reg <= 3'b000;
        end
      endcase
    end
  end

  assign bus.shift_ena = shift_ena_dec;
  assign bus.counting  = counting_dec;
  assign bus.done      = done_dec;
  assign bus.count     = count_reg;

endmodule

// File: tb/tb_delay_timer_ctrl.sv
// Directed bench: instance a uses UNIT_CYCLES=1000, instance b uses UNIT_CYCLES=4.
module tb_delay_timer_ctrl;

  logic clk;
  logic reset_n;

  delay_timer_if #(.DELAY_W(4)) bus_a ();
  delay_timer_if #(.DELAY_W(4)) bus_b ();

  delay_timer_ctrl #(.DELAY_W(4), .UNIT_CYCLES(1000), .PATTERN(4'b1101)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  delay_timer_ctrl #(.DELAY_W(4), .UNIT_CYCLES(4), .PATTERN(4'b1101)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  logic       d_in [2];
  logic       a_in [2];
  logic       se   [2];
  logic       cg   [2];
  logic       dn   [2];
  logic [3:0] ct   [2];

  assign bus_a.data = d_in[0];
  assign bus_a.ack  = a_in[0];
  assign bus_b.data = d_in[1];
  assign bus_b.ack  = a_in[1];
  assign se[0] = bus_a.shift_ena;
  assign cg[0] = bus_a.counting;
  assign dn[0] = bus_a.done;
  assign ct[0] = bus_a.count;
  assign se[1] = bus_b.shift_ena;
  assign cg[1] = bus_b.counting;
  assign dn[1] = bus_b.done;
  assign ct[1] = bus_b.count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int u, input logic [7:0] bits, input int n, input string tag);
    int early;
    early = 0;
    for (int i = n - 1; i >= 0; i--) begin
      d_in[u] = bits[i];
      step();
      if (i > 0 && se[u]) early++;
    end
    check({tag, "_premature_shift"}, early, 0);
    check({tag, "_match_shift"}, int'(se[u]), 1);
  endtask

  task automatic shift_delay(input int u, input logic [3:0] delay, input string tag);
    int nsh;
    nsh = 0;
    for (int j = 3; j >= 0; j--) begin
      d_in[u] = delay[j];
      if (se[u]) nsh++;
      step();
    end
    d_in[u] = 1'b0;
    check({tag, "_shift_cycles"}, nsh, 4);
    check({tag, "_counting_start"}, int'(cg[u]), 1);
    check({tag, "_count_loaded"}, int'(ct[u]), int'(delay));
  endtask

  task automatic measure(input int u, input int limit, output int n);
    n = 0;
    while (cg[u] && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic finish_ack(input int u, input string tag);
    check({tag, "_done"}, int'(dn[u]), 1);
    check({tag, "_done_count"}, int'(ct[u]), 0);
    a_in[u] = 1'b1;
    step();
    a_in[u] = 1'b0;
    check({tag, "_done_cleared"}, int'(dn[u]), 0);
  endtask

  typedef struct {
    logic [7:0] bits;
    int         nbits;
    logic [3:0] delay;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int held [3];
    int other;
    int bad_shift;
    int bad_done;
    int dcount;
    logic [3:0] pat;

    vecs[0] = '{bits: 8'b0000_1101, nbits: 4, delay: 4'b0010, exp_cycles: 12};
    vecs[1] = '{bits: 8'b0001_1101, nbits: 5, delay: 4'b0000, exp_cycles: 4};
    vecs[2] = '{bits: 8'b1100_1101, nbits: 8, delay: 4'b1111, exp_cycles: 64};
    vecs[3] = '{bits: 8'b0000_1101, nbits: 4, delay: 4'b0101, exp_cycles: 24};
    vecs[4] = '{bits: 8'b0000_1101, nbits: 7, delay: 4'b0001, exp_cycles: 8};

    pat = 4'b1101;
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      d_in[u] = 1'b0;
      a_in[u] = 1'b0;
    end
    repeat (3) step();
    check("reset_shift_ena", int'(se[0]), 0);
    check("reset_counting", int'(cg[0]), 0);
    check("reset_done", int'(dn[0]), 0);
    check("reset_count", int'(ct[0]), 0);
    reset_n = 1'b1;
    step();

    // Table-driven runs on the short-unit instance.
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("b_vec%0d", v);
      send_bits(1, vecs[v].bits, vecs[v].nbits, tag);
      shift_delay(1, vecs[v].delay, tag);
      measure(1, 200, n);
      check({tag, "_count_cycles"}, n, vecs[v].exp_cycles);
      finish_ack(1, tag);
    end

    // Delay 2 with pattern and ack noise injected during COUNT.
    send_bits(0, 8'b0000_1101, 4, "a_run1");
    shift_delay(0, 4'b0010, "a_run1");
    n = 0; other = 0; bad_shift = 0; bad_done = 0;
    for (int k = 0; k < 3; k++) held[k] = 0;
    while (cg[0] && n < 4000) begin
      d_in[0] = pat[3 - (n % 4)];
      a_in[0] = ((n % 7) == 3);
      if (ct[0] <= 4'd2) held[ct[0]]++;
      else other++;
      if (se[0]) bad_shift++;
      if (dn[0]) bad_done++;
      step();
      n++;
    end
    a_in[0] = 1'b0;
    check("a_run1_count_cycles", n, 3000);
    check("a_run1_held_2", held[2], 1000);
    check("a_run1_held_1", held[1], 1000);
    check("a_run1_held_0", held[0], 1000);
    check("a_run1_held_other", other, 0);
    check("a_run1_no_restart_in_count", bad_shift, 0);
    check("a_run1_no_done_in_count", bad_done, 0);
    check("a_run1_done", int'(dn[0]), 1);

    // DONE holds with ack low while the pattern is replayed.
    dcount = 0; bad_shift = 0;
    for (int k = 0; k < 50; k++) begin
      d_in[0] = pat[3 - (k % 4)];
      step();
      if (dn[0]) dcount++;
      if (se[0]) bad_shift++;
    end
    check("a_done_hold_cycles", dcount, 50);
    check("a_done_no_restart", bad_shift, 0);
    check("a_done_count_zero", int'(ct[0]), 0);
    d_in[0] = 1'b1; step();
    d_in[0] = 1'b1; step();
    d_in[0] = 1'b0;
    a_in[0] = 1'b1;
    step();
    a_in[0] = 1'b0;
    check("a_ack_done_cleared", int'(dn[0]), 0);

    // Bits seen in DONE must not seed the new search.
    send_bits(0, 8'b0000_1101, 4, "a_rearm");
    shift_delay(0, 4'b0000, "a_rearm");
    measure(0, 2000, n);
    check("a_rearm_count_cycles", n, 1000);
    finish_ack(0, "a_rearm");

    // Asynchronous reset in the middle of COUNT.
    send_bits(0, 8'b0000_1101, 4, "a_pre_rst");
    shift_delay(0, 4'b0011, "a_pre_rst");
    repeat (500) step();
    check("a_pre_rst_count_mid", int'(ct[0]), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("a_async_rst_counting", int'(cg[0]), 0);
    check("a_async_rst_count", int'(ct[0]), 0);
    check("a_async_rst_shift_ena", int'(se[0]), 0);
    check("a_async_rst_done", int'(dn[0]), 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

    send_bits(0, 8'b0000_1101, 4, "a_post_rst");
    shift_delay(0, 4'b0001, "a_post_rst");
    measure(0, 4000, n);
    check("a_post_rst_count_cycles", n, 2000);
    finish_ack(0, "a_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
